// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline encodings for interrupt sequencing and IF/ID injection
package cpu_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        INJECT = 2'd2,
        MASKED = 2'd3
    } int_state_t;
    localparam logic [3:0]  REG_NONE = 4'hF;
    localparam logic [15:0] OP_NOP   = 16'h0800;
    localparam logic [15:0] OP_INT0  = 16'hF800;
    function automatic logic reg_hit(input logic used, input logic [3:0] src, input logic [3:0] dst);
        return used && dst != REG_NONE && src == dst;
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_int_seq.sv
// int_seq: interrupt entry FSM and EPC register (built only with PIPE_CTRL_INT_EN)
module int_seq
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        int_req_i,
    input  logic        reti_i,
    input  logic        busy_i,
    input  logic [15:0] if_pc_i,
    output logic        inject_o,
    output logic [15:0] epc_o
);
    int_state_t state, next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            epc_o <= '0;
        end else begin
            state <= next;
            if (state == DRAIN && !busy_i) epc_o <= if_pc_i;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = int_req_i ? DRAIN : IDLE;
            DRAIN:   next = busy_i ? DRAIN : INJECT;
            INJECT:  next = MASKED;
            MASKED:  next = reti_i ? IDLE : MASKED;
            default: next = IDLE;
        endcase
    end

    assign inject_o = state == INJECT;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush generation for PC, IF/ID, ID/EX plus SRAM freeze.
// Interrupt entry (FSM, EPC, INT 0 injection) is built only when PIPE_CTRL_INT_EN is defined.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int SRAM_WAIT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_memread_i,
    input  logic [3:0]  ex_rd_i,
    input  logic [3:0]  id_rs_i,
    input  logic [3:0]  id_rt_i,
    input  logic        id_rs_used_i,
    input  logic        id_rt_used_i,
    input  logic        branch_taken_i,
    input  logic        mem_struct_i,
    input  logic        int_req_i,
    input  logic [15:0] if_pc_i,
    input  logic        reti_i,
    output logic        stall_pc_o,
    output logic        stall_if_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic        stall_mem_o,
    output logic        isintzero_o,
    output logic [15:0] epc_o,
    output logic        int_ack_o
);
    logic [2:0] wcnt;
    logic       waiting, st, lu, busy, inject;

    assign waiting = wcnt != 3'd0;
    assign st      = mem_struct_i && !waiting;
    assign lu      = ex_memread_i && (reg_hit(id_rs_used_i, id_rs_i, ex_rd_i) || reg_hit(id_rt_used_i, id_rt_i, ex_rd_i));
    assign busy    = waiting || branch_taken_i || st || lu;

    always_ff @(posedge CLK) begin
        if (RST) wcnt <= '0;
        else if (waiting) wcnt <= wcnt - 3'd1;
        else if (mem_struct_i) wcnt <= 3'(SRAM_WAIT);
    end

    // Wait freeze beats branch; branch beats structural/load-use; injection only adds a PC hold.
    always_comb begin
        stall_pc_o  = 1'b0;
        stall_if_o  = 1'b0;
        flush_if_o  = 1'b0;
        flush_id_o  = 1'b0;
        stall_mem_o = 1'b0;
        if (!RST) begin
            if (waiting) begin
                stall_pc_o  = 1'b1;
                stall_if_o  = 1'b1;
                stall_mem_o = 1'b1;
            end else if (branch_taken_i) begin
                flush_if_o = 1'b1;
                flush_id_o = 1'b1;
            end else begin
                stall_pc_o = st || lu || inject;
                stall_if_o = lu;
                flush_if_o = st;
                flush_id_o = lu;
            end
        end
    end

`ifdef PIPE_CTRL_INT_EN
    int_seq u_int_seq (
        .CLK      (CLK),
        .RST      (RST),
        .int_req_i(int_req_i),
        .reti_i   (reti_i),
        .busy_i   (busy),
        .if_pc_i  (if_pc_i),
        .inject_o (inject),
        .epc_o    (epc_o)
    );
`else
    logic unused_int;
    assign unused_int = ^{int_req_i, reti_i, if_pc_i, busy};
    assign inject     = 1'b0;
    assign epc_o      = '0;
`endif

    assign isintzero_o = inject && !RST;
    assign int_ack_o   = inject && !RST;
endmodule
